// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter and drain/clear flush
// sequencer owning every control input of a shared word FIFO.
module fifo_wr_arbiter #(
    parameter int N = 4,
    parameter int B = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [N*B-1:0] req_data,
    output logic [N-1:0]   req_ready,
    input  logic           cons_rd,
    output logic           cons_rd_ack,
    input  logic           flush_req,
    output logic           flush_busy,
    output logic           flush_done,
    output logic [7:0]     drain_cnt,
    input  logic           fifo_full,
    input  logic           fifo_empty,
    output logic           fifo_wr,
    output logic           fifo_rd,
    output logic           fifo_flush,
    output logic [B-1:0]   fifo_w_data
);

    localparam int LW = $clog2(N);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] last_q, last_d;
    logic [7:0]    drain_cnt_q, drain_cnt_d;

    logic [N-1:0]  elig;
    logic          grant_vld;
    logic [LW-1:0] grant;
    logic [LW:0]   idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            last_q      <= LW'(N - 1);
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Walk from lowest to highest priority so the last hit wins.
    always_comb begin
        elig      = fifo_full ? '0 : req_valid;
        grant_vld = 1'b0;
        grant     = '0;
        idx       = '0;
        for (int k = N; k >= 1; k--) begin
            idx = {1'b0, last_q} + (LW + 1)'(k);
            if (idx >= (LW + 1)'(N)) begin
                idx = idx - (LW + 1)'(N);
            end
            if (elig[idx[LW-1:0]]) begin
                grant_vld = 1'b1;
                grant     = idx[LW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        drain_cnt_d = drain_cnt_q;
        req_ready   = '0;
        fifo_wr     = 1'b0;
        fifo_rd     = 1'b0;
        cons_rd_ack = 1'b0;
        fifo_flush  = 1'b0;
        flush_done  = 1'b0;
        fifo_w_data = '0;
        flush_busy  = (state_q != RUN);

        unique case (state_q)
            RUN: begin
                if (grant_vld) begin
                    req_ready[grant] = 1'b1;
                    fifo_wr          = 1'b1;
                    last_d           = grant;
                    for (int i = 0; i < N; i++) begin
                        if (grant == LW'(i)) begin
                            fifo_w_data = req_data[i*B +: B];
                        end
                    end
                end
                cons_rd_ack = cons_rd & ~fifo_empty;
                fifo_rd     = cons_rd_ack;
                if (flush_req) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                fifo_rd = ~fifo_empty;
                if (fifo_rd && (drain_cnt_q != 8'hFF)) begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end
                if (fifo_empty) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                fifo_flush = 1'b1;
                flush_done = 1'b1;
                state_d    = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Strobes stay quiet for the whole time reset is held.
        if (reset) begin
            req_ready   = '0;
            fifo_wr     = 1'b0;
            fifo_rd     = 1'b0;
            cons_rd_ack = 1'b0;
            fifo_flush  = 1'b0;
            flush_done  = 1'b0;
            flush_busy  = 1'b0;
            fifo_w_data = '0;
        end
    end

    assign drain_cnt = drain_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scenario tasks plus randomized run against a
// behavioural model of the arbiter and a 16-deep FIFO environment.
module tb_fifo_wr_arbiter;
    localparam int N = 4;
    localparam int B = 8;
    localparam int DEPTH = 16;
    localparam int W = N + 6 + B;
    localparam int S_RUN = 0;
    localparam int S_DRAIN = 1;
    localparam int S_CLEAR = 2;

    typedef struct packed {
        logic [N-1:0] ready;
        logic         wr;
        logic         rd;
        logic         ack;
        logic         flsh;
        logic         done;
        logic         busy;
        logic [B-1:0] data;
        int           g;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*B-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           cons_rd = 1'b0;
    logic           cons_rd_ack;
    logic           flush_req = 1'b0;
    logic           flush_busy;
    logic           flush_done;
    logic [7:0]     drain_cnt;
    logic           fifo_full = 1'b0;
    logic           fifo_empty = 1'b1;
    logic           fifo_wr;
    logic           fifo_rd;
    logic           fifo_flush;
    logic [B-1:0]   fifo_w_data;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(.N(N), .B(B)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cons_rd(cons_rd), .cons_rd_ack(cons_rd_ack),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .flush_done(flush_done), .drain_cnt(drain_cnt),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_flush(fifo_flush),
        .fifo_w_data(fifo_w_data)
    );

    always #5 clk = ~clk;

    // FIFO environment: reacts to the strobes the DUT actually drives.
    logic [B-1:0] fq[$];
    logic         s_wr = 1'b0;
    logic         s_rd = 1'b0;
    logic [B-1:0] s_data = '0;

    always @(negedge clk) begin
        s_wr   <= fifo_wr;
        s_rd   <= fifo_rd;
        s_data <= fifo_w_data;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fq.delete();
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            if (s_rd && fq.size() > 0) void'(fq.pop_front());
            if (s_wr && fq.size() < DEPTH) fq.push_back(s_data);
            fifo_full  <= (fq.size() == DEPTH);
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Reference model of the arbiter behaviour.
    int   m_mode = S_RUN;
    int   m_last = N - 1;
    int   m_cnt = 0;
    exp_t ex;

    function automatic exp_t model_eval(
        input logic rst, input int mode, input int lst,
        input logic full, input logic empty,
        input logic [N-1:0] v, input logic [N*B-1:0] d, input logic crd
    );
        exp_t e;
        e = '0;
        if (rst) return e;
        if (mode == S_RUN) begin
            if (!full) begin
                for (int k = 1; k <= N; k++) begin
                    int i;
                    i = (lst + k) % N;
                    if (v[i] && !e.wr) begin
                        e.wr       = 1'b1;
                        e.ready[i] = 1'b1;
                        e.g        = i;
                        e.data     = d[i*B +: B];
                    end
                end
            end
            e.ack = crd && !empty;
            e.rd  = e.ack;
        end else if (mode == S_DRAIN) begin
            e.busy = 1'b1;
            e.rd   = !empty;
        end else begin
            e.busy = 1'b1;
            e.flsh = 1'b1;
            e.done = 1'b1;
        end
        return e;
    endfunction

    always_comb ex = model_eval(reset, m_mode, m_last, fifo_full,
                                fifo_empty, req_valid, req_data, cons_rd);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= S_RUN;
            m_last <= N - 1;
            m_cnt  <= 0;
        end else begin
            case (m_mode)
                S_RUN: begin
                    if (ex.wr) m_last <= ex.g;
                    if (flush_req) begin
                        m_mode <= S_DRAIN;
                        m_cnt  <= 0;
                    end
                end
                S_DRAIN: begin
                    if (ex.rd && m_cnt < 255) m_cnt <= m_cnt + 1;
                    if (fifo_empty) m_mode <= S_CLEAR;
                end
                default: m_mode <= S_RUN;
            endcase
        end
    end

    logic [W-1:0] obs_v;
    logic [W-1:0] exp_v;
    assign obs_v = {req_ready, fifo_wr, fifo_rd, cons_rd_ack,
                    fifo_flush, flush_done, flush_busy, fifo_w_data};
    assign exp_v = {ex.ready, ex.wr, ex.rd, ex.ack,
                    ex.flsh, ex.done, ex.busy, ex.data};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        cons_rd = 1'b0;
        flush_req = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '1;
        cons_rd = 1'b1;
        flush_req = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        checks++;
        if (obs_v !== '0) begin
            errors++;
            $display("FAIL reset_strobes got %h want 0", obs_v);
        end
        checks++;
        if (drain_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_drain_cnt got %0d want 0", drain_cnt);
        end
        req_valid = '0;
        cons_rd = 1'b0;
        flush_req = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_empty_guard();
        cons_rd = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({fifo_rd, cons_rd_ack} !== 2'b00) begin
                errors++;
                $display("FAIL empty_guard c%0d got rd=%b ack=%b want 0 0",
                         c, fifo_rd, cons_rd_ack);
            end
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL empty_model c%0d got %h want %h", c, obs_v, exp_v);
            end
            cyc();
        end
        cons_rd = 1'b0;
    endtask

    task automatic test_fairness();
        logic [N-1:0] er;
        logic [B-1:0] ed;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = '1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            er = (c < 16) ? (N'(1) << (c % N)) : '0;
            ed = (c < 16) ? B'(16 + c % N) : '0;
            checks++;
            if ({req_ready, fifo_w_data} !== {er, ed}) begin
                errors++;
                $display("FAIL rr_grant c%0d got %b/%h want %b/%h",
                         c, req_ready, fifo_w_data, er, ed);
            end
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL rr_model c%0d got %h want %h", c, obs_v, exp_v);
            end
            cyc();
        end
        checks++;
        if (fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL rr_full got %b want 1", fifo_full);
        end
    endtask

    task automatic test_full_guard();
        logic [N-1:0] er[3];
        logic         ew;
        er = '{4'b0000, 4'b0001, 4'b0010};
        cons_rd = 1'b1;
        req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ew = (c != 0) ? 1'b1 : 1'b0;
            checks++;
            if ({req_ready, fifo_wr, fifo_rd} !== {er[c], ew, 1'b1}) begin
                errors++;
                $display("FAIL full_guard c%0d got %b/%b/%b want %b/%b/1",
                         c, req_ready, fifo_wr, fifo_rd, er[c], ew);
            end
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL full_model c%0d got %h want %h", c, obs_v, exp_v);
            end
            cyc();
        end
        cons_rd = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_flush_data();
        int busy_n, rd_n, fl_n, done_at;
        do_reset();
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL fd_fill c%0d got %h want %h", c, obs_v, exp_v);
            end
            cyc();
        end
        req_valid = '0;
        flush_req = 1'b1;
        busy_n = 0;
        rd_n = 0;
        fl_n = 0;
        done_at = -1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL fd_model c%0d got %h want %h", c, obs_v, exp_v);
            end
            if (flush_busy) busy_n++;
            if (fifo_rd) rd_n++;
            if (fifo_flush) fl_n++;
            if (flush_done && done_at < 0) done_at = c;
            cyc();
            flush_req = 1'b0;
        end
        checks++;
        if ({busy_n, rd_n, fl_n, done_at} !== {32'd7, 32'd5, 32'd1, 32'd7}) begin
            errors++;
            $display("FAIL fd_timing got busy=%0d rd=%0d fl=%0d done@%0d want 7 5 1 7",
                     busy_n, rd_n, fl_n, done_at);
        end
        checks++;
        if ({drain_cnt, fifo_empty} !== {8'd5, 1'b1}) begin
            errors++;
            $display("FAIL fd_count got cnt=%0d empty=%b want 5 1",
                     drain_cnt, fifo_empty);
        end
        req_valid = '1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL fd_resume got %b want 0010", req_ready);
        end
        cyc();
        req_valid = '0;
        cons_rd = 1'b1;
        cyc();
        cons_rd = 1'b0;
    endtask

    task automatic test_flush_empty();
        int busy_n, rd_n, done_at;
        flush_req = 1'b1;
        busy_n = 0;
        rd_n = 0;
        done_at = -1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (flush_busy) busy_n++;
            if (fifo_rd) rd_n++;
            if (flush_done && done_at < 0) done_at = c;
            cyc();
            flush_req = 1'b0;
        end
        checks++;
        if ({busy_n, rd_n, done_at} !== {32'd2, 32'd0, 32'd2}) begin
            errors++;
            $display("FAIL fe_timing got busy=%0d rd=%0d done@%0d want 2 0 2",
                     busy_n, rd_n, done_at);
        end
        checks++;
        if (drain_cnt !== 8'd0) begin
            errors++;
            $display("FAIL fe_count got %0d want 0", drain_cnt);
        end
    endtask

    task automatic test_reset_drain();
        int rd_n;
        req_valid = '1;
        repeat (6) cyc();
        req_valid = '0;
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        rd_n = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (fifo_rd) rd_n++;
            cyc();
        end
        checks++;
        if ({rd_n, drain_cnt, flush_busy} !== {32'd2, 8'd2, 1'b1}) begin
            errors++;
            $display("FAIL rd_pre got rd=%0d cnt=%0d busy=%b want 2 2 1",
                     rd_n, drain_cnt, flush_busy);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({obs_v, drain_cnt} !== '0) begin
            errors++;
            $display("FAIL rd_reset got %h cnt=%0d want 0 0", obs_v, drain_cnt);
        end
        cyc();
        reset = 1'b0;
        req_valid = '1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rd_last got %b want 0001", req_ready);
        end
        cyc();
        req_valid = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] rdy;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL rnd_model c%0d got %h want %h", c, obs_v, exp_v);
            end
            checks++;
            if (drain_cnt !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL rnd_cnt c%0d got %0d want %0d", c, drain_cnt, m_cnt);
            end
            rdy = ex.ready;
            cyc();
            flush_req = ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0;
            cons_rd = ($urandom_range(0, 99) < ((c < 200) ? 25 : 70)) ? 1'b1 : 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !rdy[i])) begin
                    req_valid[i] = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
                    req_data[i*B +: B] = B'($urandom);
                end
            end
        end
        req_valid = '0;
        cons_rd = 1'b0;
        flush_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_empty_guard();
        test_fairness();
        test_full_guard();
        test_flush_data();
        test_flush_empty();
        test_reset_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
